// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC into a combinational ROM, with a small in-order buffer toward decode.
// Fetched word is visible at out_* one cycle later; with out_ready low the head holds and fetch stalls once the buffer is full.

module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [31:0] fetch_cnt
);
  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic        push;
  logic        pop;
  logic        buf_empty;
  logic        buf_full;
  ent_t        push_ent;
  ent_t        head_ent;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign out_valid = !buf_empty;
  assign pop       = out_valid && out_ready;
  assign out_pc    = head_ent.pc;
  assign out_instr = head_ent.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A full buffer still accepts a push when the head leaves in the same cycle.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        push = fetch_en && !redirect_valid && (!buf_full || pop);
        if (!fetch_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_ent       = '0;
    push_ent.pc    = pc_q;
    push_ent.instr = imem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      fetch_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        pc_q <= pc_q + 32'd4;
      end
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  // Redirect flushes the buffer; a pop in the same cycle is still treated as accepted downstream.
  ifu_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .empty    (buf_empty),
    .full     (buf_full)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences, random run vs queue model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_en, redirect_valid, out_ready, out_valid;
  logic [31:0] redirect_pc, imem_addr, imem_data, out_instr, out_pc, fetch_cnt;
  logic        fetch_en_b, redirect_valid_b, out_ready_b, out_valid_b;
  logic [31:0] redirect_pc_b, imem_addr_b, imem_data_b, out_instr_b, out_pc_b, fetch_cnt_b;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h0050_0513;
      32'h0000_0004: rom = 32'h0075_0593;
      32'h0000_0008: rom = 32'h0025_2513;
      32'h0000_0098: rom = 32'h00B5_0463;
      default:       rom = {8'h13, a[23:0]};
    endcase
  endfunction

  assign imem_data   = rom(imem_addr);
  assign imem_data_b = rom(imem_addr_b);

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready), .fetch_cnt(fetch_cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en_b), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b), .out_valid(out_valid_b),
    .out_instr(out_instr_b), .out_pc(out_pc_b), .out_ready(out_ready_b), .fetch_cnt(fetch_cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] ecnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit fe, bit rdy, bit rv, logic [31:0] rpc, bit ev,
                              logic [31:0] eaddr, logic [31:0] epc, logic [31:0] einstr, logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.eaddr = eaddr; v.epc = epc; v.einstr = einstr; v.ecnt = ecnt;
    return v;
  endfunction

  // Reference model: queue of fetched {pc, instr}, next PC, push count, and whether fetching was enabled last cycle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;
  localparam int MDEPTH = 2;
  ment_t       mq[$];
  logic [31:0] mpc;
  logic [31:0] mcnt;
  bit          mrun;

  task automatic model_reset();
    mq.delete();
    mpc  = 32'h0;
    mcnt = 32'h0;
    mrun = 1'b0;
  endtask

  task automatic model_step();
    bit    pop, push;
    ment_t e;
    pop  = (mq.size() != 0) && out_ready;
    push = mrun && fetch_en && !redirect_valid && ((mq.size() < MDEPTH) || pop);
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = mpc;
        e.instr = rom(mpc);
        mq.push_back(e);
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
      end
    end
    mrun = fetch_en;
  endtask

  vec_t tbl[26];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0,1,1,0,32'h0,   0,32'h0,  32'h0,  32'h0,        0);
    tbl[1]  = mk(0,1,1,0,32'h0,   1,32'h4,  32'h0,  32'h0050_0513,1);
    tbl[2]  = mk(0,1,1,0,32'h0,   1,32'h8,  32'h4,  32'h0075_0593,2);
    tbl[3]  = mk(0,1,1,0,32'h0,   1,32'hC,  32'h8,  32'h0025_2513,3);
    tbl[4]  = mk(1,0,0,0,32'h0,   0,32'h0,  32'h0,  32'h0,        0);
    tbl[5]  = mk(0,1,0,0,32'h0,   0,32'h0,  32'h0,  32'h0,        0);
    tbl[6]  = mk(0,1,0,0,32'h0,   1,32'h4,  32'h0,  32'h0050_0513,1);
    for (int i = 7; i <= 12; i++)
      tbl[i] = mk(0,1,0,0,32'h0,  1,32'h8,  32'h0,  32'h0050_0513,2);
    tbl[13] = mk(0,1,1,0,32'h0,   1,32'hC,  32'h4,  32'h0075_0593,3);
    tbl[14] = mk(0,1,1,0,32'h0,   1,32'h10, 32'h8,  32'h0025_2513,4);
    tbl[15] = mk(0,1,0,0,32'h0,   1,32'h10, 32'h8,  32'h0025_2513,4);
    tbl[16] = mk(0,1,0,1,32'h9A,  0,32'h98, 32'h0,  32'h0,        4);
    tbl[17] = mk(0,1,1,0,32'h0,   1,32'h9C, 32'h98, 32'h00B5_0463,5);
    tbl[18] = mk(0,1,1,0,32'h0,   1,32'hA0, 32'h9C, 32'h1300_009C,6);
    tbl[19] = mk(0,0,1,0,32'h0,   0,32'hA0, 32'h0,  32'h0,        6);
    tbl[20] = mk(0,0,1,0,32'h0,   0,32'hA0, 32'h0,  32'h0,        6);
    tbl[21] = mk(0,1,1,0,32'h0,   0,32'hA0, 32'h0,  32'h0,        6);
    tbl[22] = mk(0,1,1,0,32'h0,   1,32'hA4, 32'hA0, 32'h1300_00A0,7);
    tbl[23] = mk(0,0,0,1,32'h203, 0,32'h200,32'h0,  32'h0,        7);
    tbl[24] = mk(0,1,1,0,32'h0,   0,32'h200,32'h0,  32'h0,        7);
    tbl[25] = mk(0,1,1,0,32'h0,   1,32'h204,32'h200,32'h1300_0200,8);

    rst_n = 1'b0;
    fetch_en = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    fetch_en_b = 0; redirect_valid_b = 0; redirect_pc_b = 0; out_ready_b = 0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);

    for (int i = 0; i < 26; i++) begin
      rst_n          = !tbl[i].rst;
      fetch_en       = tbl[i].fe;
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d_cnt", i), fetch_cnt, tbl[i].ecnt);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].einstr);
      end
    end

    // Half-cycle reset pulse with two entries buffered.
    rst_n = 1; redirect_valid = 0; fetch_en = 1; out_ready = 0;
    tick();
    chk("pulse_pre_valid", 32'(out_valid), 32'h1);
    chk("pulse_pre_cnt", fetch_cnt, 32'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_valid", 32'(out_valid), 32'h0);
    chk("pulse_addr", imem_addr, 32'h0);
    chk("pulse_cnt", fetch_cnt, 32'h0);
    #4 rst_n = 1'b1;
    out_ready = 1;
    tick();
    chk("pulse_first_edge_valid", 32'(out_valid), 32'h0);
    chk("pulse_first_edge_addr", imem_addr, 32'h0);
    tick();
    chk("pulse_second_edge_pc", out_pc, 32'h0);
    chk("pulse_second_edge_instr", out_instr, 32'h0050_0513);

    // PC wrap and depth-4 saturation on the second instance.
    fetch_en = 0; out_ready = 0;
    fetch_en_b = 1; out_ready_b = 1;
    tick();
    chk("wrap_run_valid", 32'(out_valid_b), 32'h0);
    tick();
    chk("wrap_pc0", out_pc_b, 32'hFFFF_FFF8);
    chk("wrap_instr0", out_instr_b, 32'h13FF_FFF8);
    tick();
    chk("wrap_pc1", out_pc_b, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", out_pc_b, 32'h0);
    chk("wrap_instr2", out_instr_b, 32'h0050_0513);
    chk("wrap_addr", imem_addr_b, 32'h4);
    out_ready_b = 0;
    repeat (6) tick();
    chk("d4_full_pc", out_pc_b, 32'h0);
    chk("d4_full_addr", imem_addr_b, 32'h10);
    chk("d4_full_cnt", fetch_cnt_b, 32'd6);
    out_ready_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("d4_drain%0d_pc", i), out_pc_b, 32'(4 + 4 * i));
    end
    chk("d4_drain_cnt", fetch_cnt_b, 32'd10);
    fetch_en_b = 0; out_ready_b = 0;

    // Random run against the queue model, with occasional mid-run resets.
    rst_n = 0;
    model_reset();
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst_n          = 1'b1;
      fetch_en       = ($urandom_range(0, 9) < 8);
      out_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        model_step();
      end
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_addr", imem_addr, mpc);
      chk("rnd_cnt", fetch_cnt, mcnt);
      if (mq.size() != 0) begin
        chk("rnd_pc", out_pc, mq[0].pc);
        chk("rnd_instr", out_instr, mq[0].instr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
